// File: rtl/uart_tx_sched_if.sv
// Handshake bundle between the two requesters, the config register and the UART transmitter.
// The slave modport is the scheduler's view; master is the environment driving it.
interface uart_tx_sched_if;
   logic [15:0] A_DATA;
   logic        A_VALID;
   logic        A_READY;
   logic [7:0]  B_DATA;
   logic        B_VALID;
   logic        B_READY;
   logic        CFG_PAR_EN;
   logic        CFG_PAR_TYP;
   logic        TX_BUSY;
   logic [7:0]  TX_P_DATA;
   logic        TX_DATA_VALID;
   logic        TX_PAR_EN;
   logic        TX_PAR_TYP;
   logic        SCHED_BUSY;
   logic        TO_ERR;

   modport slave (
      input  A_DATA, A_VALID, B_DATA, B_VALID, CFG_PAR_EN, CFG_PAR_TYP, TX_BUSY,
      output A_READY, B_READY, TX_P_DATA, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP,
             SCHED_BUSY, TO_ERR
   );

   modport master (
      output A_DATA, A_VALID, B_DATA, B_VALID, CFG_PAR_EN, CFG_PAR_TYP, TX_BUSY,
      input  A_READY, B_READY, TX_P_DATA, TX_DATA_VALID, TX_PAR_EN, TX_PAR_TYP,
             SCHED_BUSY, TO_ERR
   );
endinterface

// File: rtl/uart_tx_sched.sv
// Round-robin frame scheduler sharing one UART transmitter between a 2-byte port A and a
// 1-byte port B, with per-transfer parity latching and a Busy-rise watchdog.
module uart_tx_sched #(
   parameter int unsigned BUSY_TIMEOUT = 8
) (
   input  logic           CLK,
   input  logic           RST,
   uart_tx_sched_if.slave bus
);

   typedef enum logic [1:0] {IDLE, ISSUE, WAIT_HI, WAIT_LO} state_t;

   localparam logic [7:0] TO_LAST = 8'(BUSY_TIMEOUT - 1);

   state_t      r_state, w_state_next;
   logic        r_ptr, w_ptr_next;          // 0: A has priority, 1: B has priority
   logic [7:0]  r_hi, w_hi_next;            // upper A byte awaiting its frame
   logic [1:0]  r_cnt, w_cnt_next;
   logic [7:0]  r_to_cnt, w_to_cnt_next;
   logic [7:0]  r_tx_data, w_tx_data_next;
   logic        r_tx_dv, w_tx_dv_next;
   logic        r_par_en, w_par_en_next;
   logic        r_par_typ, w_par_typ_next;
   logic        r_to_err, w_to_err_next;
   logic        w_can_grant, w_grant_a, w_grant_b;

   // RST gates the grant so READY is low while reset is held, not just after it.
   assign w_can_grant = (r_state == IDLE) && !bus.TX_BUSY && !RST;
   assign w_grant_a   = w_can_grant && bus.A_VALID && (!bus.B_VALID || !r_ptr);
   assign w_grant_b   = w_can_grant && bus.B_VALID && (!bus.A_VALID ||  r_ptr);

   always_comb begin
      w_state_next   = r_state;
      w_ptr_next     = r_ptr;
      w_hi_next      = r_hi;
      w_cnt_next     = r_cnt;
      w_to_cnt_next  = r_to_cnt;
      w_tx_data_next = r_tx_data;
      w_par_en_next  = r_par_en;
      w_par_typ_next = r_par_typ;
      w_tx_dv_next   = 1'b0;
      w_to_err_next  = 1'b0;

      case (r_state)
         IDLE: begin
            if (w_grant_a) begin
               w_hi_next      = bus.A_DATA[15:8];
               w_tx_data_next = bus.A_DATA[7:0];
               w_cnt_next     = 2'd2;
               w_ptr_next     = 1'b1;
               w_par_en_next  = bus.CFG_PAR_EN;
               w_par_typ_next = bus.CFG_PAR_TYP;
               w_tx_dv_next   = 1'b1;
               w_state_next   = ISSUE;
            end else if (w_grant_b) begin
               w_hi_next      = 8'h00;
               w_tx_data_next = bus.B_DATA;
               w_cnt_next     = 2'd1;
               w_ptr_next     = 1'b0;
               w_par_en_next  = bus.CFG_PAR_EN;
               w_par_typ_next = bus.CFG_PAR_TYP;
               w_tx_dv_next   = 1'b1;
               w_state_next   = ISSUE;
            end
         end
         ISSUE: begin
            w_to_cnt_next = 8'd0;
            w_state_next  = WAIT_HI;
         end
         WAIT_HI: begin
            if (bus.TX_BUSY) begin
               w_state_next = WAIT_LO;
            end else if (r_to_cnt == TO_LAST) begin
               // Transmitter never started: drop the rest of the transfer.
               w_to_err_next = 1'b1;
               w_cnt_next    = 2'd0;
               w_state_next  = IDLE;
            end else begin
               w_to_cnt_next = r_to_cnt + 8'd1;
            end
         end
         WAIT_LO: begin
            if (!bus.TX_BUSY) begin
               w_cnt_next = r_cnt - 2'd1;
               if (r_cnt == 2'd2) begin
                  w_tx_data_next = r_hi;
                  w_tx_dv_next   = 1'b1;
                  w_state_next   = ISSUE;
               end else begin
                  w_state_next = IDLE;
               end
            end
         end
         default: w_state_next = IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         r_state   <= IDLE;
         r_ptr     <= 1'b0;
         r_hi      <= 8'h00;
         r_cnt     <= 2'd0;
         r_to_cnt  <= 8'd0;
         r_tx_data <= 8'h00;
         r_tx_dv   <= 1'b0;
         r_par_en  <= 1'b0;
         r_par_typ <= 1'b0;
         r_to_err  <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_ptr     <= w_ptr_next;
         r_hi      <= w_hi_next;
         r_cnt     <= w_cnt_next;
         r_to_cnt  <= w_to_cnt_next;
         r_tx_data <= w_tx_data_next;
         r_tx_dv   <= w_tx_dv_next;
         r_par_en  <= w_par_en_next;
         r_par_typ <= w_par_typ_next;
         r_to_err  <= w_to_err_next;
      end
   end

   assign bus.A_READY       = w_grant_a;
   assign bus.B_READY       = w_grant_b;
   assign bus.TX_P_DATA     = r_tx_data;
   assign bus.TX_DATA_VALID = r_tx_dv;
   assign bus.TX_PAR_EN     = r_par_en;
   assign bus.TX_PAR_TYP    = r_par_typ;
   assign bus.SCHED_BUSY    = (r_state != IDLE);
   assign bus.TO_ERR        = r_to_err;

endmodule

// File: tb/tb_uart_tx_sched.sv
// Directed bench for uart_tx_sched: frames are predicted into a scoreboard when stimulus is
// driven and popped when TX_DATA_VALID is seen; a small transmitter model answers with Busy.
module tb_uart_tx_sched;

   typedef struct packed {
      logic [7:0] d;
      logic       pe;
      logic       pt;
   } exp_t;

   logic CLK = 1'b0;
   logic RST = 1'b1;
   always #5 CLK = ~CLK;

   uart_tx_sched_if bus();

   uart_tx_sched #(.BUSY_TIMEOUT(8)) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   logic xm_busy      = 1'b0;
   logic foreign_busy = 1'b0;
   bit   xm_en        = 1'b1;
   int   xm_len       = 11;
   assign bus.TX_BUSY = xm_busy | foreign_busy;

   // Transmitter model: Busy rises one cycle after the start pulse and lasts xm_len cycles.
   initial begin
      forever begin
         @(negedge CLK);
         if (bus.TX_DATA_VALID === 1'b1 && xm_en) begin
            @(posedge CLK);
            #1 xm_busy = 1'b1;
            repeat (xm_len) @(posedge CLK);
            #1 xm_busy = 1'b0;
         end
      end
   end

   exp_t sb[$];
   int   n_cmp = 0;
   int   n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic push_exp(input logic [7:0] d, input logic pe, input logic pt);
      exp_t e;
      e.d  = d;
      e.pe = pe;
      e.pt = pt;
      sb.push_back(e);
   endtask

   task automatic expect_frame(input string tag, input int budget);
      bit   seen = 1'b0;
      exp_t e;
      for (int i = 0; i < budget; i++) begin
         @(negedge CLK);
         if (bus.TX_DATA_VALID === 1'b1) begin
            seen = 1'b1;
            break;
         end
      end
      chk({tag, "_dv"}, 32'(seen), 32'd1);
      if (seen) begin
         chk({tag, "_sb_nonempty"}, 32'(sb.size() != 0), 32'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk({tag, "_data"}, 32'(bus.TX_P_DATA), 32'(e.d));
            chk({tag, "_par_en"}, 32'(bus.TX_PAR_EN), 32'(e.pe));
            chk({tag, "_par_typ"}, 32'(bus.TX_PAR_TYP), 32'(e.pt));
            chk({tag, "_sched_busy"}, 32'(bus.SCHED_BUSY), 32'd1);
         end
      end
   endtask

   task automatic wait_busy_fall(input string tag);
      bit rose = 1'b0;
      bit fell = 1'b0;
      for (int i = 0; i < 60 && !fell; i++) begin
         @(negedge CLK);
         if (bus.TX_BUSY === 1'b1) rose = 1'b1;
         else if (rose) fell = 1'b1;
      end
      chk({tag, "_busy_fall"}, 32'(fell), 32'd1);
   endtask

   task automatic wait_ready(input string tag, input bit is_a);
      bit seen = 1'b0;
      for (int i = 0; i < 10 && !seen; i++) begin
         @(negedge CLK);
         if (is_a ? (bus.A_READY === 1'b1) : (bus.B_READY === 1'b1)) seen = 1'b1;
      end
      chk({tag, "_ready"}, 32'(seen), 32'd1);
   endtask

   task automatic idle_window(input string tag, input int n);
      bit any_dv = 1'b0;
      for (int i = 0; i < n; i++) begin
         @(negedge CLK);
         if (bus.TX_DATA_VALID !== 1'b0) any_dv = 1'b1;
      end
      chk({tag, "_no_dv"}, 32'(any_dv), 32'd0);
   endtask

   task automatic do_reset(input string tag);
      RST = 1'b1;
      bus.A_VALID = 1'b1;
      bus.B_VALID = 1'b1;
      repeat (2) @(negedge CLK);
      chk({tag, "_a_ready"}, 32'(bus.A_READY), 32'd0);
      chk({tag, "_b_ready"}, 32'(bus.B_READY), 32'd0);
      chk({tag, "_tx_dv"}, 32'(bus.TX_DATA_VALID), 32'd0);
      chk({tag, "_tx_data"}, 32'(bus.TX_P_DATA), 32'd0);
      chk({tag, "_sched_busy"}, 32'(bus.SCHED_BUSY), 32'd0);
      chk({tag, "_to_err"}, 32'(bus.TO_ERR), 32'd0);
      bus.A_VALID = 1'b0;
      bus.B_VALID = 1'b0;
      @(posedge CLK);
      #1 RST = 1'b0;
   endtask

   initial begin
      bit any_to;
      bit any_rdy;
      bus.A_DATA      = 16'h0000;
      bus.A_VALID     = 1'b0;
      bus.B_DATA      = 8'h00;
      bus.B_VALID     = 1'b0;
      bus.CFG_PAR_EN  = 1'b0;
      bus.CFG_PAR_TYP = 1'b0;

      do_reset("rst0");

      // B alone, long Busy
      xm_len = 11;
      bus.CFG_PAR_EN = 1'b1; bus.CFG_PAR_TYP = 1'b0;
      bus.B_DATA = 8'hA5; bus.B_VALID = 1'b1;
      push_exp(8'hA5, 1'b1, 1'b0);
      wait_ready("t1", 1'b0);
      @(posedge CLK); #1 bus.B_VALID = 1'b0;
      expect_frame("t1", 1);
      wait_busy_fall("t1");
      chk("t1_sched_hold", 32'(bus.SCHED_BUSY), 32'd1);
      @(negedge CLK);
      chk("t1_sched_idle", 32'(bus.SCHED_BUSY), 32'd0);

      // A alone, two bytes low first
      xm_len = 3;
      @(posedge CLK); #1;
      bus.CFG_PAR_EN = 1'b0; bus.CFG_PAR_TYP = 1'b0;
      bus.A_DATA = 16'h3C7E; bus.A_VALID = 1'b1;
      push_exp(8'h7E, 1'b0, 1'b0);
      push_exp(8'h3C, 1'b0, 1'b0);
      wait_ready("t2", 1'b1);
      @(posedge CLK); #1 bus.A_VALID = 1'b0;
      expect_frame("t2_b0", 1);
      wait_busy_fall("t2_b0");
      expect_frame("t2_b1", 1);
      wait_busy_fall("t2_b1");
      @(negedge CLK);
      chk("t2_sched_idle", 32'(bus.SCHED_BUSY), 32'd0);

      // Both valid from reset: A, then B, then A again
      do_reset("rst1");
      xm_len = 2;
      bus.CFG_PAR_EN = 1'b1; bus.CFG_PAR_TYP = 1'b1;
      bus.A_DATA = 16'h1234; bus.B_DATA = 8'h55;
      bus.A_VALID = 1'b1; bus.B_VALID = 1'b1;
      push_exp(8'h34, 1'b1, 1'b1);
      push_exp(8'h12, 1'b1, 1'b1);
      push_exp(8'h55, 1'b1, 1'b1);
      expect_frame("t3_a0", 2);
      wait_busy_fall("t3_a0");
      expect_frame("t3_a1", 1);
      wait_busy_fall("t3_a1");
      expect_frame("t3_b", 2);
      wait_busy_fall("t3_b");
      @(negedge CLK);
      chk("t3_rr_a_ready", 32'(bus.A_READY), 32'd1);
      chk("t3_rr_b_ready", 32'(bus.B_READY), 32'd0);
      bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
      idle_window("t3_withdraw", 4);
      chk("t3_sched_idle", 32'(bus.SCHED_BUSY), 32'd0);

      // Transmitter never starts
      xm_en = 1'b0;
      @(posedge CLK); #1;
      bus.CFG_PAR_EN = 1'b0; bus.CFG_PAR_TYP = 1'b1;
      bus.A_DATA = 16'hBEEF; bus.A_VALID = 1'b1;
      push_exp(8'hEF, 1'b0, 1'b1);
      wait_ready("t4", 1'b1);
      @(posedge CLK); #1 bus.A_VALID = 1'b0;
      expect_frame("t4", 1);
      any_to = 1'b0;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         if (bus.TO_ERR !== 1'b0) any_to = 1'b1;
      end
      chk("t4_to_early", 32'(any_to), 32'd0);
      chk("t4_sched_wait", 32'(bus.SCHED_BUSY), 32'd1);
      @(negedge CLK);
      chk("t4_to_pulse", 32'(bus.TO_ERR), 32'd1);
      chk("t4_sched_idle", 32'(bus.SCHED_BUSY), 32'd0);
      @(negedge CLK);
      chk("t4_to_clear", 32'(bus.TO_ERR), 32'd0);
      idle_window("t4_no_b1", 6);
      xm_en = 1'b1;
      @(posedge CLK); #1;
      bus.CFG_PAR_EN = 1'b1; bus.CFG_PAR_TYP = 1'b1;
      bus.B_DATA = 8'hC3; bus.B_VALID = 1'b1;
      push_exp(8'hC3, 1'b1, 1'b1);
      wait_ready("t4_next", 1'b0);
      @(posedge CLK); #1 bus.B_VALID = 1'b0;
      expect_frame("t4_next", 1);
      wait_busy_fall("t4_next");
      @(negedge CLK);

      // Parity type changes between the two A bytes
      @(posedge CLK); #1;
      bus.CFG_PAR_EN = 1'b1; bus.CFG_PAR_TYP = 1'b0;
      bus.A_DATA = 16'h9A5B; bus.A_VALID = 1'b1;
      push_exp(8'h5B, 1'b1, 1'b0);
      push_exp(8'h9A, 1'b1, 1'b0);
      wait_ready("t5", 1'b1);
      @(posedge CLK); #1 bus.A_VALID = 1'b0;
      expect_frame("t5_b0", 1);
      bus.CFG_PAR_TYP = 1'b1;
      wait_busy_fall("t5_b0");
      expect_frame("t5_b1", 1);
      wait_busy_fall("t5_b1");
      @(posedge CLK); #1;
      bus.B_DATA = 8'h66; bus.B_VALID = 1'b1;
      push_exp(8'h66, 1'b1, 1'b1);
      wait_ready("t5_next", 1'b0);
      @(posedge CLK); #1 bus.B_VALID = 1'b0;
      expect_frame("t5_next", 1);
      wait_busy_fall("t5_next");
      @(negedge CLK);

      // Foreign frame holds Busy while idle
      @(posedge CLK); #1;
      foreign_busy = 1'b1;
      bus.CFG_PAR_EN = 1'b0; bus.CFG_PAR_TYP = 1'b0;
      bus.B_DATA = 8'h0F; bus.B_VALID = 1'b1;
      push_exp(8'h0F, 1'b0, 1'b0);
      any_rdy = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         if (bus.B_READY !== 1'b0) any_rdy = 1'b1;
      end
      chk("t6_no_grant_busy", 32'(any_rdy), 32'd0);
      @(posedge CLK); #1 foreign_busy = 1'b0;
      wait_ready("t6", 1'b0);
      @(posedge CLK); #1 bus.B_VALID = 1'b0;
      expect_frame("t6", 1);
      wait_busy_fall("t6");
      @(negedge CLK);

      // Reset during WAIT_LO of A byte 0
      xm_len = 6;
      @(posedge CLK); #1;
      bus.CFG_PAR_EN = 1'b1; bus.CFG_PAR_TYP = 1'b1;
      bus.A_DATA = 16'h7788; bus.A_VALID = 1'b1;
      push_exp(8'h88, 1'b1, 1'b1);
      wait_ready("t7", 1'b1);
      @(posedge CLK); #1 bus.A_VALID = 1'b0;
      expect_frame("t7_b0", 1);
      repeat (2) @(negedge CLK);
      chk("t7_sched_pre", 32'(bus.SCHED_BUSY), 32'd1);
      #2 RST = 1'b1;
      #1;
      chk("t7_async_sched", 32'(bus.SCHED_BUSY), 32'd0);
      chk("t7_async_data", 32'(bus.TX_P_DATA), 32'd0);
      chk("t7_async_par_en", 32'(bus.TX_PAR_EN), 32'd0);
      chk("t7_async_par_typ", 32'(bus.TX_PAR_TYP), 32'd0);
      chk("t7_async_dv", 32'(bus.TX_DATA_VALID), 32'd0);
      @(posedge CLK); #1 RST = 1'b0;
      wait_busy_fall("t7");
      idle_window("t7_no_b1", 6);
      chk("t7_sb_drained", 32'(sb.size()), 32'd0);
      @(posedge CLK); #1;
      bus.A_VALID = 1'b1; bus.B_VALID = 1'b1;
      @(negedge CLK);
      chk("t7_ptr_a_ready", 32'(bus.A_READY), 32'd1);
      chk("t7_ptr_b_ready", 32'(bus.B_READY), 32'd0);
      bus.A_VALID = 1'b0; bus.B_VALID = 1'b0;
      idle_window("t7_end", 3);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
